// File: rtl/comp_mul_arb.sv
// comp_mul_arb: round-robin arbiter/sequencer that shares one complex multiplier among NREQ
// requesters. The winner's operands are latched and sent to the multiplier with a one-cycle
// m_en pulse. The arbiter then waits for m_o_en, or for TIMEOUT cycles if the multiplier
// stalls. Finally it returns the product on a shared response bus, together with the
// requester id and a one-hot ack pulse.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req[NREQ]         per-port request, held with stable operands until ack
//   op_data           slot i = op_data[i*4*DW +: 4*DW] = {a_r, a_i, b_r, b_i}, signed
//   ack[NREQ]         one-hot, one-cycle pulse to the served port
//   rsp_valid         one-cycle pulse; rsp_id/rsp_r/rsp_i/rsp_err hold until the next one
//   rsp_id            served requester index
//   rsp_r, rsp_i      product real/imaginary parts, bit-exact from the multiplier
//   rsp_err           multiplier timed out, result forced to 0
//   busy              high in any state but IDLE
//   m_en              multiplier start pulse
//   m_a_r..m_b_i      multiplier operands, stable from ISSUE through DONE
//   m_o_r, m_o_i      multiplier results
//   m_o_en            multiplier result valid (only honoured in WAIT)
module comp_mul_arb #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int DW      = 8,
  parameter int OW      = 17,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*4*DW-1:0] op_data,
  output logic [NREQ-1:0]    ack,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [OW-1:0]      rsp_r,
  output logic [OW-1:0]      rsp_i,
  output logic               rsp_err,
  output logic               busy,
  output logic               m_en,
  output logic [DW-1:0]      m_a_r,
  output logic [DW-1:0]      m_a_i,
  output logic [DW-1:0]      m_b_r,
  output logic [DW-1:0]      m_b_i,
  input  logic [OW-1:0]      m_o_r,
  input  logic [OW-1:0]      m_o_i,
  input  logic               m_o_en
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]     state_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] id_q;
  logic [7:0]     timer_q;

  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic [4*DW-1:0] grant_slot;

  // Two-pass search: first the ports above rr_ptr, then wrap to 0..rr_ptr.
  // The second pass includes rr_ptr itself, so a lone requester is always served.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req[i] && (IDW'(i) > rr_ptr_q)) begin
        grant_found = 1'b1;
        grant_id    = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req[i] && (IDW'(i) <= rr_ptr_q)) begin
        grant_found = 1'b1;
        grant_id    = IDW'(i);
      end
    end
  end

  assign grant_slot = op_data[int'(grant_id)*4*DW +: 4*DW];

  assign busy      = (state_q != S_IDLE);
  assign m_en      = (state_q == S_ISSUE);
  assign rsp_valid = (state_q == S_DONE);

  always_comb begin
    ack = '0;
    if (state_q == S_DONE) begin
      ack[id_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= IDW'(NREQ - 1);
      id_q     <= '0;
      timer_q  <= '0;
      m_a_r    <= '0;
      m_a_i    <= '0;
      m_b_r    <= '0;
      m_b_i    <= '0;
      rsp_id   <= '0;
      rsp_r    <= '0;
      rsp_i    <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_found) begin
            id_q     <= grant_id;
            rr_ptr_q <= grant_id;
            m_a_r    <= grant_slot[4*DW-1 -: DW];
            m_a_i    <= grant_slot[3*DW-1 -: DW];
            m_b_r    <= grant_slot[2*DW-1 -: DW];
            m_b_i    <= grant_slot[DW-1 -: DW];
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A real result wins over a simultaneous timeout.
          if (m_o_en) begin
            rsp_r   <= m_o_r;
            rsp_i   <= m_o_i;
            rsp_err <= 1'b0;
            rsp_id  <= id_q;
            state_q <= S_DONE;
          end else if (timer_q == 8'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th WAIT cycle.
            rsp_r   <= '0;
            rsp_i   <= '0;
            rsp_err <= 1'b1;
            rsp_id  <= id_q;
            state_q <= S_DONE;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comp_mul_arb.sv
// tb_comp_mul_arb: directed bench for comp_mul_arb, driving it through a behavioural
// multiplier stub. The stub can be disabled to model a stalled multiplier.
module tb_comp_mul_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int DW   = 8;
  localparam int OW   = 17;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*4*DW-1:0] op_data = '0;
  logic [NREQ-1:0]      ack;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [OW-1:0]        rsp_r, rsp_i;
  logic                 rsp_err, busy, m_en;
  logic [DW-1:0]        m_a_r, m_a_i, m_b_r, m_b_i;
  logic [OW-1:0]        m_o_r, m_o_i;
  logic                 m_o_en;

  comp_mul_arb #(.NREQ(NREQ), .IDW(IDW), .DW(DW), .OW(OW), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req(req), .op_data(op_data), .ack(ack),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_r(rsp_r), .rsp_i(rsp_i),
    .rsp_err(rsp_err), .busy(busy), .m_en(m_en),
    .m_a_r(m_a_r), .m_a_i(m_a_i), .m_b_r(m_b_r), .m_b_i(m_b_i),
    .m_o_r(m_o_r), .m_o_i(m_o_i), .m_o_en(m_o_en)
  );

  always #5 clk = ~clk;

  // Multiplier stub: result valid two cycles after m_en is seen.
  logic           stub_on = 1'b1;
  logic           pend, stub_oen;
  logic [OW-1:0]  stub_r, stub_i;
  int             cap_ar, cap_ai, cap_br, cap_bi;
  logic           spur_en = 1'b0;
  logic [OW-1:0]  spur_val = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0; stub_oen <= 1'b0; stub_r <= '0; stub_i <= '0;
    end else begin
      stub_oen <= 1'b0;
      if (m_en && stub_on) begin
        pend   <= 1'b1;
        cap_ar <= int'($signed(m_a_r)); cap_ai <= int'($signed(m_a_i));
        cap_br <= int'($signed(m_b_r)); cap_bi <= int'($signed(m_b_i));
      end else if (pend) begin
        pend     <= 1'b0;
        stub_oen <= 1'b1;
        stub_r   <= OW'(cap_ar * cap_br - cap_ai * cap_bi);
        stub_i   <= OW'(cap_ar * cap_bi + cap_ai * cap_br);
      end
    end
  end

  assign m_o_en = stub_oen | spur_en;
  assign m_o_r  = spur_en ? spur_val : stub_r;
  assign m_o_i  = spur_en ? spur_val : stub_i;

  // Event counters and the operands seen on the last m_en pulse.
  int mcnt = 0;
  int rvcnt = 0;
  int last_ar, last_ai, last_br, last_bi;
  always @(posedge clk) begin
    if (m_en) begin
      mcnt <= mcnt + 1;
      last_ar <= int'($signed(m_a_r)); last_ai <= int'($signed(m_a_i));
      last_br <= int'($signed(m_b_r)); last_bi <= int'($signed(m_b_i));
    end
    if (rsp_valid) rvcnt <= rvcnt + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic set_slot(input int p, input int ar, input int ai, input int br, input int bi);
    op_data[p*4*DW +: 4*DW] = {DW'(ar), DW'(ai), DW'(br), DW'(bi)};
  endtask

  // Wait (bounded) on negedges for rsp_valid; n = negedges waited.
  task automatic wait_rsp(input int limit, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (!ok && n < limit) begin
      @(negedge clk);
      n++;
      if (rsp_valid) ok = 1'b1;
    end
    if (!ok) chk("rsp_wait_expired", 0, 1);
  endtask

  task automatic wait_men(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      @(negedge clk);
      n++;
      if (m_en) ok = 1'b1;
    end
    if (!ok) chk("men_wait_expired", 0, 1);
  endtask

  // Checked at the negedge inside the DONE cycle.
  task automatic chk_rsp(input string name, input int id, input int er, input int ei,
                         input int eerr);
    chk({name, "_id"}, int'(rsp_id), id);
    chk({name, "_r"}, int'($signed(rsp_r)), er);
    chk({name, "_i"}, int'($signed(rsp_i)), ei);
    chk({name, "_err"}, int'(rsp_err), eerr);
    chk({name, "_ack"}, int'(ack), 1 << id);
  endtask

  task automatic chk_idle_zero(input string name);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_men"}, int'(m_en), 0);
    chk({name, "_ack"}, int'(ack), 0);
    chk({name, "_rv"}, int'(rsp_valid), 0);
    chk({name, "_rsp"}, int'({rsp_r, rsp_i, rsp_err, rsp_id}), 0);
    chk({name, "_ops"}, int'({m_a_r, m_a_i, m_b_r, m_b_i}), 0);
  endtask

  typedef struct {
    int port;
    int ar, ai, br, bi;
    int er, ei;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n, m0;
    bit ok;
    int hold_r;
    int order[6];

    vecs[0] = '{3, -128, -128, -128, -128, 0, 32768};
    vecs[1] = '{0, 2, 3, 4, -1, 11, 10};
    vecs[2] = '{2, -7, 5, 6, 2, -52, 16};
    vecs[3] = '{3, 127, 127, 127, -128, 32385, -127};
    vecs[4] = '{0, -128, 0, -128, 0, 16384, 0};
    vecs[5] = '{1, 0, 127, 0, 127, -16129, 0};

    #1;
    chk_idle_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Single op with operand, pulse-count and latency checks.
    set_slot(1, 3, 4, 1, 2);
    m0 = mcnt;
    req[1] = 1'b1;
    wait_men(ok);
    chk("t1_busy_issue", int'(busy), 1);
    wait_rsp(20, n, ok);
    req[1] = 1'b0;
    chk("t1_latency", n, 3);
    chk_rsp("t1", 1, -5, 10, 0);
    chk("t1_men_pulses", mcnt - m0, 1);
    chk("t1_ops", (last_ar << 24) | (last_ai << 16) | (last_br << 8) | last_bi,
        (3 << 24) | (4 << 16) | (1 << 8) | 2);

    // Table of single-port ops including operand extremes.
    for (int v = 0; v < 6; v++) begin
      set_slot(vecs[v].port, vecs[v].ar, vecs[v].ai, vecs[v].br, vecs[v].bi);
      m0 = mcnt;
      req[vecs[v].port] = 1'b1;
      wait_rsp(20, n, ok);
      req[vecs[v].port] = 1'b0;
      chk_rsp($sformatf("vec%0d", v), vecs[v].port, vecs[v].er, vecs[v].ei, 0);
      chk($sformatf("vec%0d_men", v), mcnt - m0, 1);
    end

    // Fairness from reset: all four held high.
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    set_slot(0, 2, 3, 4, -1);
    set_slot(1, 3, 4, 1, 2);
    set_slot(2, -7, 5, 6, 2);
    set_slot(3, 127, 127, 127, -128);
    order = '{0, 1, 2, 3, 0, 1};
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_rsp(20, n, ok);
      case (order[k])
        0: chk_rsp($sformatf("rr%0d", k), 0, 11, 10, 0);
        1: chk_rsp($sformatf("rr%0d", k), 1, -5, 10, 0);
        2: chk_rsp($sformatf("rr%0d", k), 2, -52, 16, 0);
        default: chk_rsp($sformatf("rr%0d", k), 3, 32385, -127, 0);
      endcase
    end
    req = '0;

    // Timeout: stalled multiplier, then a normal op is still served.
    @(negedge clk);
    stub_on = 1'b0;
    set_slot(1, 5, 6, 7, 8);
    req[1] = 1'b1;
    wait_men(ok);
    wait_rsp(40, n, ok);
    req[1] = 1'b0;
    chk("to_latency", n, 16);
    chk_rsp("to", 1, 0, 0, 1);
    stub_on = 1'b1;
    set_slot(2, -7, 5, 6, 2);
    req[2] = 1'b1;
    wait_rsp(20, n, ok);
    req[2] = 1'b0;
    chk_rsp("after_to", 2, -52, 16, 0);

    // Reset mid-WAIT on a port-0 op (rr_ptr would become 0).
    @(negedge clk);
    set_slot(0, 2, 3, 4, -1);
    stub_on = 1'b0;
    req[0] = 1'b1;
    wait_men(ok);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_idle_zero("rst_wait");
    m0 = rvcnt;
    req = 4'b1001;
    @(negedge clk);
    rst = 1'b0;
    stub_on = 1'b1;
    wait_rsp(20, n, ok);
    chk("rst_no_stray_rsp", rvcnt - m0, 0);
    req[0] = 1'b0;
    chk_rsp("rst_first", 0, 11, 10, 0);
    wait_rsp(20, n, ok);
    req[3] = 1'b0;
    chk_rsp("rst_second", 3, 32385, -127, 0);
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    req[2] = 1'b1;
    wait_rsp(20, n, ok);
    req[2] = 1'b0;
    chk_rsp("rst_req2", 2, -52, 16, 0);

    // Spurious m_o_en in IDLE.
    @(negedge clk);
    m0 = rvcnt;
    spur_val = 17'h1abcd;
    spur_en = 1'b1;
    @(negedge clk);
    spur_en = 1'b0;
    chk("spur_idle_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    chk("spur_idle_rsp", int'($signed(rsp_r)), -52);
    chk("spur_idle_rv", rvcnt - m0, 0);

    // Spurious m_o_en in DONE.
    m0 = rvcnt;
    req[0] = 1'b1;
    wait_rsp(20, n, ok);
    req[0] = 1'b0;
    hold_r = int'($signed(rsp_r));
    chk("spur_done_r0", hold_r, 11);
    spur_en = 1'b1;
    @(negedge clk);
    spur_en = 1'b0;
    chk("spur_done_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("spur_done_r", int'($signed(rsp_r)), 11);
    chk("spur_done_i", int'($signed(rsp_i)), 10);
    chk("spur_done_rv", rvcnt - m0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
